// File: rtl/cmd_pkg.sv
// Shared definitions for the host command responder: opcodes, parser
// states and reply geometry.
package cmd_pkg;

   // Command opcodes carried in the first byte of each packet
   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;

   // A read reply is one 32-bit word sent as four bytes, LSB first
   localparam int REPLY_BYTES = 4;
   localparam int CNT_W       = 3;

   // Packet parser states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA0  = 3'd2,
      ST_DATA1  = 3'd3,
      ST_DATA2  = 3'd4,
      ST_DATA3  = 3'd5,
      ST_RDWAIT = 3'd6
   } parser_state_t;

   // Increment an 8-bit error counter, sticking at 255
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/reply_serializer.sv
// Four-byte reply buffer: loads one 32-bit read result and hands it out
// LSB first over the byte handshake, tracking how many bytes remain.
//
// Handshake: o_avail high means o_data holds a valid byte and it stays
// stable until consumed. i_accept is a one-cycle pulse; it consumes the
// current byte only when o_avail is high (otherwise it is ignored) and the
// next byte, or o_avail=0 after the last one, appears in the following cycle.
module reply_serializer
   import cmd_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_load,
   input  logic [8*REPLY_BYTES-1:0]    i_word,
   input  logic                        i_accept,
   input  logic                        i_request_length,
   output logic                        o_avail,
   output logic [7:0]                  o_data,
   output logic                        o_empty,
   output logic [CNT_W-1:0]            o_count,
   output logic [15:0]                 o_length
);

   logic [8*REPLY_BYTES-1:0] r_shift;
   logic [CNT_W-1:0]         r_count;
   logic [15:0]              r_length;
   logic [CNT_W-1:0]         w_count_next;
   logic                     w_take;

   assign w_take = i_accept && (r_count != '0);

   // Pending-byte count after this cycle's load or accept
   always_comb begin
      w_count_next = r_count;
      if (i_load) begin
         w_count_next = CNT_W'(REPLY_BYTES);
      end else if (w_take) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Byte shift register and pending count; the parser only loads when empty
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shift <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
         if (i_load) begin
            r_shift <= i_word;
         end else if (w_take) begin
            r_shift <= {8'h00, r_shift[8*REPLY_BYTES-1:8]};
         end
      end
   end

   // Length snapshot; reflects an accept landing in the same cycle
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_length <= '0;
      end else if (i_request_length) begin
         r_length <= 16'(w_count_next);
      end
   end

   assign o_avail  = (r_count != '0);
   assign o_data   = r_shift[7:0];
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_length = r_length;

endmodule

// File: rtl/cmd_responder.sv
// FPGA-side responder for host register commands. Parses READ/WRITE packets
// from the FX2 command byte stream, drives the 32-bit register bus and
// returns read data through the reply serializer.
module cmd_responder
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 48000,
   parameter int TIMEOUT_W      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_wr,
   input  logic [7:0]    cmd_in,
   output logic          data_avail,
   output logic [7:0]    data,
   input  logic          data_accepted,
   input  logic          request_length,
   output logic [15:0]   length,
   output logic [7:0]    reg_addr,
   output logic [31:0]   reg_wdata,
   output logic          reg_wr,
   output logic          reg_rd,
   input  logic [31:0]   reg_rdata,
   output logic          busy,
   output logic [7:0]    err_count,
   output parser_state_t dbg_state
);

   localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

   parser_state_t          r_state;
   logic                   r_is_read;
   logic [7:0]             r_reg_addr;
   logic [31:0]            r_reg_wdata;
   logic                   r_reg_wr;
   logic                   r_reg_rd;
   logic [TIMEOUT_W-1:0]   r_timer;
   logic [7:0]             r_err_count;

   logic                   w_load;
   logic                   w_ser_empty;
   logic [CNT_W-1:0]       w_ser_count;

   // reg_rdata is valid the cycle after the reg_rd pulse, i.e. the second
   // RDWAIT cycle, which is exactly when reg_rd has dropped again
   assign w_load = (r_state == ST_RDWAIT) && !r_reg_rd;

   // Packet parser, bus strobes, inter-byte timeout and error counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_is_read   <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
         r_timer     <= '0;
         r_err_count <= '0;
      end else begin
         r_reg_wr <= 1'b0;
         r_reg_rd <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_timer <= '0;
               if (cmd_wr) begin
                  if (cmd_in == OP_READ || cmd_in == OP_WRITE) begin
                     r_is_read <= (cmd_in == OP_READ);
                     r_state   <= ST_ADDR;
                  end else begin
                     r_err_count <= sat_inc8(r_err_count);
                  end
               end
            end
            ST_RDWAIT: begin
               // Bytes arriving here have no packet to belong to and are dropped
               r_timer <= '0;
               if (!r_reg_rd) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               if (cmd_wr) begin
                  r_timer <= '0;
                  case (r_state)
                     ST_ADDR: begin
                        r_reg_addr <= cmd_in;
                        if (!r_is_read) begin
                           r_state <= ST_DATA0;
                        end else if (w_ser_empty) begin
                           r_reg_rd <= 1'b1;
                           r_state  <= ST_RDWAIT;
                        end else begin
                           // Previous reply still draining: refuse the read
                           r_err_count <= sat_inc8(r_err_count);
                           r_state     <= ST_IDLE;
                        end
                     end
                     ST_DATA0: begin
                        r_reg_wdata <= {cmd_in, r_reg_wdata[31:8]};
                        r_state     <= ST_DATA1;
                     end
                     ST_DATA1: begin
                        r_reg_wdata <= {cmd_in, r_reg_wdata[31:8]};
                        r_state     <= ST_DATA2;
                     end
                     ST_DATA2: begin
                        r_reg_wdata <= {cmd_in, r_reg_wdata[31:8]};
                        r_state     <= ST_DATA3;
                     end
                     ST_DATA3: begin
                        r_reg_wdata <= {cmd_in, r_reg_wdata[31:8]};
                        r_reg_wr    <= 1'b1;
                        r_state     <= ST_IDLE;
                     end
                     default: begin
                        r_state <= ST_IDLE;
                     end
                  endcase
               end else if (r_timer == TO_LIMIT) begin
                  // Host went quiet mid-packet: abandon it without a strobe
                  r_timer     <= '0;
                  r_err_count <= sat_inc8(r_err_count);
                  r_state     <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
         endcase
      end
   end

   reply_serializer u_reply (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_load           (w_load),
      .i_word           (reg_rdata),
      .i_accept         (data_accepted),
      .i_request_length (request_length),
      .o_avail          (data_avail),
      .o_data           (data),
      .o_empty          (w_ser_empty),
      .o_count          (w_ser_count),
      .o_length         (length)
   );

   assign reg_addr  = r_reg_addr;
   assign reg_wdata = r_reg_wdata;
   assign reg_wr    = r_reg_wr;
   assign reg_rd    = r_reg_rd;
   assign err_count = r_err_count;
   assign busy      = (r_state != ST_IDLE) || (w_ser_count != '0);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: drives host packets and reply accepts,
// with a scoreboard of expected bus writes, bus reads and reply bytes.
module tb_cmd_responder;
   import cmd_pkg::*;

   localparam int TO_CYC = 50;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_wr;
   logic [7:0]    cmd_in;
   logic          data_avail;
   logic [7:0]    data;
   logic          data_accepted;
   logic          request_length;
   logic [15:0]   length;
   logic [7:0]    reg_addr;
   logic [31:0]   reg_wdata;
   logic          reg_wr;
   logic          reg_rd;
   logic [31:0]   reg_rdata;
   logic          busy;
   logic [7:0]    err_count;
   parser_state_t dbg_state;

   int n_vec  = 0;
   int n_fail = 0;

   logic [39:0] exp_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   logic [7:0]  exp_byte_q[$];

   logic [31:0] rd_value;
   logic        rd_seen;

   cmd_responder #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_wr         (cmd_wr),
      .cmd_in         (cmd_in),
      .data_avail     (data_avail),
      .data           (data),
      .data_accepted  (data_accepted),
      .request_length (request_length),
      .length         (length),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_wr         (reg_wr),
      .reg_rd         (reg_rd),
      .reg_rdata      (reg_rdata),
      .busy           (busy),
      .err_count      (err_count),
      .dbg_state      (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      cmd_wr = 1'b1;
      cmd_in = b;
      tick(1);
      cmd_wr = 1'b0;
      cmd_in = 8'h00;
      if (gap > 1) tick(gap - 1);
   endtask

   task automatic req_len(input logic [15:0] exp_len);
      request_length = 1'b1;
      tick(1);
      request_length = 1'b0;
      check("length_request", 40'(length), 40'(exp_len));
   endtask

   // Wait for a reply byte, accept it two cycles later, optionally asking
   // for the length in the same cycle
   task automatic accept_byte(input logic with_len, input logic [15:0] exp_len);
      int waited = 0;
      while (!data_avail && waited < 20) begin
         tick(1);
         waited++;
      end
      if (!data_avail) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_wait: data_avail=0 after 20 cycles, expected 1");
      end else begin
         tick(2);
         data_accepted  = 1'b1;
         request_length = with_len;
         tick(1);
         data_accepted  = 1'b0;
         request_length = 1'b0;
         if (with_len) check("length_with_accept", 40'(length), 40'(exp_len));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_avail"}, 40'(data_avail), 40'd0);
      check({tag, "_data"},       40'(data),       40'd0);
      check({tag, "_length"},     40'(length),     40'd0);
      check({tag, "_reg_addr"},   40'(reg_addr),   40'd0);
      check({tag, "_reg_wdata"},  40'(reg_wdata),  40'd0);
      check({tag, "_reg_wr"},     40'(reg_wr),     40'd0);
      check({tag, "_reg_rd"},     40'(reg_rd),     40'd0);
      check({tag, "_busy"},       40'(busy),       40'd0);
      check({tag, "_err_count"},  40'(err_count),  40'd0);
      check({tag, "_state"},      40'(dbg_state),  40'(ST_IDLE));
   endtask

   task automatic do_reset(input string tag);
      reset          = 1'b1;
      cmd_wr         = 1'b0;
      data_accepted  = 1'b0;
      request_length = 1'b0;
      tick(2);
      check_reset_outputs(tag);
      reset = 1'b0;
      tick(1);
   endtask

   // Register slave: read data is valid only in the cycle after reg_rd
   initial begin
      reg_rdata = 32'h0;
      forever begin
         @(negedge clk);
         rd_seen = reg_rd;
         @(posedge clk);
         #1;
         reg_rdata = rd_seen ? rd_value : 32'hA5A5_5A5A;
      end
   end

   // Monitor: compare bus strobes and accepted reply bytes against the queues
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (reg_wr) begin
               if (exp_wr_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_reg_wr: addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
               end else begin
                  check("reg_wr_addr_data", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
               end
            end
            if (reg_rd) begin
               if (exp_rd_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_reg_rd: addr 0x%0h, expected no read", reg_addr);
               end else begin
                  check("reg_rd_addr", 40'(reg_addr), 40'(exp_rd_q.pop_front()));
               end
            end
            if (data_avail && data_accepted) begin
               if (exp_byte_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_reply_byte: 0x%0h, expected none", data);
               end else begin
                  check("reply_byte", 40'(data), 40'(exp_byte_q.pop_front()));
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      reset          = 1'b1;
      cmd_wr         = 1'b0;
      cmd_in         = 8'h00;
      data_accepted  = 1'b0;
      request_length = 1'b0;
      rd_value       = 32'h0;
      @(posedge clk);
      #1;

      // Reset state and a spaced-out WRITE
      do_reset("rst0");
      exp_wr_q.push_back({8'h10, 32'h1234_5678});
      send_byte(8'h02, 3);
      send_byte(8'h10, 3);
      send_byte(8'h78, 3);
      send_byte(8'h56, 3);
      send_byte(8'h34, 3);
      send_byte(8'h12, 3);
      tick(2);
      check("wr_err_count", 40'(err_count), 40'd0);
      check("wr_busy", 40'(busy), 40'd0);

      // READ with latency check and full drain
      rd_value = 32'hDEAD_BEEF;
      exp_rd_q.push_back(8'h20);
      exp_byte_q.push_back(8'hEF);
      exp_byte_q.push_back(8'hBE);
      exp_byte_q.push_back(8'hAD);
      exp_byte_q.push_back(8'hDE);
      send_byte(8'h01, 3);
      send_byte(8'h20, 1);
      check("rd_lat_c1_avail", 40'(data_avail), 40'd0);
      tick(1);
      check("rd_lat_c2_avail", 40'(data_avail), 40'd0);
      tick(1);
      check("rd_lat_c3_avail", 40'(data_avail), 40'd1);
      check("rd_busy_during_reply", 40'(busy), 40'd1);
      for (int i = 0; i < 4; i++) accept_byte(1'b0, 16'd0);
      check("rd_avail_after_last", 40'(data_avail), 40'd0);
      check("rd_busy_after_last", 40'(busy), 40'd0);

      // Bad opcode followed by a good WRITE
      do_reset("rst1");
      send_byte(8'h55, 2);
      check("badop_err_count", 40'(err_count), 40'd1);
      exp_wr_q.push_back({8'h33, 32'h0403_0201});
      send_byte(8'h02, 2);
      send_byte(8'h33, 2);
      send_byte(8'h01, 2);
      send_byte(8'h02, 2);
      send_byte(8'h03, 2);
      send_byte(8'h04, 2);
      tick(2);
      check("badop_err_after_wr", 40'(err_count), 40'd1);

      // Inter-byte timeout mid-WRITE, then a READ still works
      do_reset("rst2");
      send_byte(8'h02, 1);
      send_byte(8'h10, 1);
      send_byte(8'hAA, 1);
      tick(40);
      check("to_busy_before", 40'(busy), 40'd1);
      tick(11);
      check("to_busy_after", 40'(busy), 40'd0);
      check("to_err_count", 40'(err_count), 40'd1);
      rd_value = 32'h1122_3344;
      exp_rd_q.push_back(8'h44);
      exp_byte_q.push_back(8'h44);
      exp_byte_q.push_back(8'h33);
      exp_byte_q.push_back(8'h22);
      exp_byte_q.push_back(8'h11);
      send_byte(8'h01, 2);
      send_byte(8'h44, 2);
      for (int i = 0; i < 4; i++) accept_byte(1'b0, 16'd0);
      check("to_read_err_count", 40'(err_count), 40'd1);

      // READ overrun while two bytes are outstanding, plus length tracking
      do_reset("rst3");
      rd_value = 32'hA1B2_C3D4;
      exp_rd_q.push_back(8'h50);
      exp_byte_q.push_back(8'hD4);
      exp_byte_q.push_back(8'hC3);
      exp_byte_q.push_back(8'hB2);
      exp_byte_q.push_back(8'hA1);
      send_byte(8'h01, 2);
      send_byte(8'h50, 2);
      accept_byte(1'b0, 16'd0);
      accept_byte(1'b0, 16'd0);
      req_len(16'd2);
      send_byte(8'h01, 2);
      send_byte(8'h60, 3);
      check("ovr_err_count", 40'(err_count), 40'd1);
      check("ovr_avail", 40'(data_avail), 40'd1);
      accept_byte(1'b1, 16'd1);
      accept_byte(1'b1, 16'd0);
      check("ovr_avail_end", 40'(data_avail), 40'd0);

      // Reset during DATA2: no write, nothing resumes
      do_reset("rst4");
      send_byte(8'h02, 2);
      send_byte(8'h10, 2);
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      check("mid_state_data2", 40'(dbg_state), 40'(ST_DATA2));
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_data2");
      tick(1);
      reset = 1'b0;
      tick(1);
      send_byte(8'h33, 2);
      send_byte(8'h44, 2);
      check("post_rst_err_count", 40'(err_count), 40'd2);
      check("post_rst_busy", 40'(busy), 40'd0);

      // Reset during a reply: stale bytes are gone for good
      rd_value = 32'h0A0B_0C0D;
      exp_rd_q.push_back(8'h70);
      exp_byte_q.push_back(8'h0D);
      send_byte(8'h01, 2);
      send_byte(8'h70, 2);
      accept_byte(1'b0, 16'd0);
      req_len(16'd3);
      #2;
      reset = 1'b1;
      #1;
      check("rst_reply_avail", 40'(data_avail), 40'd0);
      check("rst_reply_data", 40'(data), 40'd0);
      check("rst_reply_length", 40'(length), 40'd0);
      check("rst_reply_busy", 40'(busy), 40'd0);
      tick(1);
      reset = 1'b0;
      tick(10);
      check("stale_avail", 40'(data_avail), 40'd0);
      check("stale_busy", 40'(busy), 40'd0);

      // Every expected transaction was observed
      check("wr_q_drained", 40'(exp_wr_q.size()), 40'd0);
      check("rd_q_drained", 40'(exp_rd_q.size()), 40'd0);
      check("byte_q_drained", 40'(exp_byte_q.size()), 40'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
